// File: rtl/mem_access_sequencer_if.sv
// Request, memory and response signals between the granted-packet master and the sequencer.
// The slave modport is the sequencer's view; master is the requester/memory side.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_write;
  logic              req_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rdata_ack;
  logic              wr_done;
  logic              timeout_err;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, mem_rdata, mem_rvalid,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
           rdata, rdata_ack, wr_done, timeout_err, busy
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_write, mem_rdata, mem_rvalid,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
           rdata, rdata_ack, wr_done, timeout_err, busy
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// One-packet-at-a-time memory sequencer: write done 2 cycles after accept, read ack 1 cycle after rvalid
// or after TIMEOUT wait cycles with ERR_DATA; req_ready only in IDLE, so requests back up until idle.
module mem_access_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_access_sequencer_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, WDONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    bus.req_ready   = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.rdata_ack   = 1'b0;
    bus.wr_done     = 1'b0;
    bus.timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so every output reads 0 while reset is held.
        bus.req_ready = ~reset;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = write_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        cnt_d         = '0;
        err_d         = 1'b0;
        state_d       = write_q ? WDONE : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        bus.rdata_ack   = 1'b1;
        bus.timeout_err = err_q;
        err_d           = 1'b0;
        state_d         = IDLE;
      end
      WDONE: begin
        bus.wr_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
